// File: rtl/mips_mc_controller.sv
// mips_mc_controller
//   Control unit for the multi-cycle MIPS datapath. A Moore FSM steps each
//   instruction through fetch, decode, execute, memory and writeback over
//   the shared memory and ALU. It also holds the ALU function decoder, a
//   sticky illegal-opcode flag and a retired-instruction counter.
//
// Ports
//   clk          rising-edge system clock
//   reset        asynchronous, active-low reset
//   op, funct    instruction[31:26] and instruction[5:0] from the IR
//   zero         ALU zero flag (only consulted in BRANCH)
//   pcen         PC load enable = pcwrite | (branch & zero)
//   memwrite     data memory write strobe
//   irwrite      instruction register load
//   regwrite     register file write
//   iord         memory address select (0 PC, 1 ALUOut)
//   memtoreg     writeback select (0 ALUOut, 1 MDR)
//   regdst       destination select (0 rt, 1 rd)
//   alusrca      ALU A select (0 PC, 1 rs)
//   alusrcb      ALU B select (00 rt, 01 4, 10 imm, 11 imm<<2)
//   pcsrc        PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   alucontrol   ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   illegal      sticky, set when an unsupported opcode/funct halts the FSM
//   instr_count  instructions retired since reset, wraps silently
module mips_mc_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXECUTE = 4'd6;
  localparam logic [3:0] ALUWB   = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;
  localparam logic [3:0] HALT    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Internal ALU op class produced by the FSM, refined by the funct decoder.
  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;

  logic [3:0] state;
  logic [3:0] state_nxt;

  logic       pcwrite;
  logic       branch;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic [1:0] aluop;

  logic [2:0] fn_alu;
  logic       fn_ok;

  // ---------------------------------------------------------------------
  // R-type funct decoder
  // ---------------------------------------------------------------------
  always_comb begin
    fn_alu = ALU_ADD;
    fn_ok  = 1'b1;
    case (funct)
      FN_ADD:  fn_alu = ALU_ADD;
      FN_SUB:  fn_alu = ALU_SUB;
      FN_AND:  fn_alu = ALU_AND;
      FN_OR:   fn_alu = ALU_OR;
      FN_SLT:  fn_alu = ALU_SLT;
      default: fn_ok  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default:      state_nxt = HALT;
        endcase
      end
      // op is still held in the IR here, so it picks the load or store leg.
      MEMADR:  state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_nxt = MEMWB;
      MEMWB:   state_nxt = FETCH;
      MEMWR:   state_nxt = FETCH;
      EXECUTE: state_nxt = fn_ok ? ALUWB : HALT;
      ALUWB:   state_nxt = FETCH;
      BRANCH:  state_nxt = FETCH;
      ADDIEX:  state_nxt = ADDIWB;
      ADDIWB:  state_nxt = FETCH;
      JUMP:    state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, sticky illegal flag and retire counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
    end else if (state != HALT && state_nxt == HALT) begin
      illegal <= 1'b1;
    end
  end

  // Every return to FETCH closes an instruction; HALT never returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (state != FETCH && state_nxt == FETCH) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = AOP_ADD;
    case (state)
      FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b01;
        pcwrite   = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = AOP_FN;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    case (aluop)
      AOP_SUB: alucontrol = ALU_SUB;
      AOP_FN:  alucontrol = fn_alu;
      default: alucontrol = ALU_ADD;
    endcase
  end

  // Enables are qualified by reset combinationally so that pulling reset
  // low drops any in-flight write at once, not on the next clock edge.
  assign pcen     = reset & (pcwrite | (branch & zero));
  assign memwrite = reset & memwrite_s;
  assign irwrite  = reset & irwrite_s;
  assign regwrite = reset & regwrite_s;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller
//   Scoreboard bench for mips_mc_controller. Each scenario pushes the
//   expected per-cycle output vector (from a table model of the state
//   outputs) into a queue, then pops and compares one entry per cycle.
//   The counter is built 3 bits wide so wrap-around is reached quickly.
module tb_mips_mc_controller;

  localparam int unsigned W = 3;

  localparam int S_F   = 0;
  localparam int S_D   = 1;
  localparam int S_MA  = 2;
  localparam int S_MR  = 3;
  localparam int S_MWB = 4;
  localparam int S_MWR = 5;
  localparam int S_EX  = 6;
  localparam int S_AWB = 7;
  localparam int S_BR  = 8;
  localparam int S_AE  = 9;
  localparam int S_AW  = 10;
  localparam int S_J   = 11;
  localparam int S_H   = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [5:0]   op = '0;
  logic [5:0]   funct = '0;
  logic         zero = 1'b0;
  logic         pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0]   alusrcb, pcsrc;
  logic [2:0]   alucontrol;
  logic         illegal;
  logic [W-1:0] instr_count;

  logic [14:0]  obs;
  logic [W-1:0] exp_count;
  int           total = 0;
  int           bad = 0;

  typedef struct packed {
    logic [14:0] v;
    logic [14:0] m;
  } exp_t;
  exp_t q[$];

  mips_mc_controller #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol};

  // Table model of the controller outputs for one state.
  function automatic logic [14:0] model(input int st, input logic z,
                                        input logic [5:0] f, input logic in_rst);
    logic pe, mw, iw, rw, io, mt, rd, sa;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {pe, mw, iw, rw, io, mt, rd, sa} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    case (st)
      S_F:   begin iw = 1'b1; sb = 2'b01; pe = 1'b1; end
      S_D:   sb = 2'b11;
      S_MA:  begin sa = 1'b1; sb = 2'b10; end
      S_MR:  io = 1'b1;
      S_MWB: begin mt = 1'b1; rw = 1'b1; end
      S_MWR: begin io = 1'b1; mw = 1'b1; end
      S_EX: begin
        sa = 1'b1;
        if (f == 6'b100010) ac = 3'b110;
        else if (f == 6'b100100) ac = 3'b000;
        else if (f == 6'b100101) ac = 3'b001;
        else if (f == 6'b101010) ac = 3'b111;
      end
      S_AWB: begin rd = 1'b1; rw = 1'b1; end
      S_BR:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
      S_AE:  begin sa = 1'b1; sb = 2'b10; end
      S_AW:  rw = 1'b1;
      S_J:   begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    if (in_rst) {pe, mw, iw, rw} = 4'b0000;
    return {pe, mw, iw, rw, io, mt, rd, sa, sb, ps, ac};
  endfunction

  task automatic push(input int st);
    exp_t e;
    e.v = model(st, zero, funct, 1'b0);
    e.m = '1;
    q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0; op = '0; funct = '0; zero = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== model(S_F, 1'b0, 6'h0, 1'b1)) begin
        bad++; $display("FAIL reset_out cyc%0d got=%b want=%b", i, obs, model(S_F, 1'b0, 6'h0, 1'b1));
      end
      total++;
      if (illegal !== 1'b0 || instr_count !== '0) begin
        bad++; $display("FAIL reset_regs got ill=%b cnt=%0d want ill=0 cnt=0", illegal, instr_count);
      end
      @(posedge clk); @(negedge clk);
    end
    reset = 1'b1;
    exp_count = '0;
  endtask

  task automatic test_lw();
    exp_t e;
    int i = 0;
    op = 6'b100011; zero = 1'b0;
    push(S_F); push(S_D); push(S_MA); push(S_MR); push(S_MWB);
    while (q.size() > 0) begin
      #1; e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++; $display("FAIL lw cyc%0d got=%b want=%b", i, obs, e.v);
      end
      @(posedge clk); @(negedge clk); i++;
    end
    exp_count = exp_count + 1'b1;
    #1; total++;
    if (instr_count !== exp_count) begin
      bad++; $display("FAIL lw_count got=%0d want=%0d", instr_count, exp_count);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fl [5];
    exp_t e;
    fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100;
    fl[3] = 6'b100101; fl[4] = 6'b101010;
    for (int k = 0; k < 5; k++) begin
      int i = 0;
      op = 6'b000000; funct = fl[k];
      push(S_F); push(S_D); push(S_EX); push(S_AWB);
      while (q.size() > 0) begin
        #1; e = q.pop_front();
        total++;
        if (obs !== e.v) begin
          bad++; $display("FAIL rtype f=%b cyc%0d got=%b want=%b", fl[k], i, obs, e.v);
        end
        @(posedge clk); @(negedge clk); i++;
      end
      exp_count = exp_count + 1'b1;
      #1; total++;
      if (instr_count !== exp_count) begin
        bad++; $display("FAIL rtype_count got=%0d want=%0d", instr_count, exp_count);
      end
    end
  endtask

  task automatic test_beq();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      int i = 0;
      op = 6'b000100; funct = 6'h0; zero = (k == 0);
      push(S_F); push(S_D); push(S_BR);
      while (q.size() > 0) begin
        #1; e = q.pop_front();
        total++;
        if (obs !== e.v) begin
          bad++; $display("FAIL beq z=%b cyc%0d got=%b want=%b", zero, i, obs, e.v);
        end
        @(posedge clk); @(negedge clk); i++;
      end
      exp_count = exp_count + 1'b1;
      #1; total++;
      if (instr_count !== exp_count) begin
        bad++; $display("FAIL beq_count got=%0d want=%0d", instr_count, exp_count);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw();
    exp_t e;
    int i = 0;
    op = 6'b101011;
    push(S_F); push(S_D); push(S_MA); push(S_MWR);
    while (q.size() > 0) begin
      #1; e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++; $display("FAIL sw cyc%0d got=%b want=%b", i, obs, e.v);
      end
      @(posedge clk); @(negedge clk); i++;
    end
    exp_count = exp_count + 1'b1;
    #1; total++;
    if (instr_count !== exp_count) begin
      bad++; $display("FAIL sw_count got=%0d want=%0d", instr_count, exp_count);
    end
  endtask

  // addi immediately followed by j; zero held high to show it is ignored.
  task automatic test_back_to_back();
    exp_t e;
    int i = 0;
    op = 6'b001000; zero = 1'b1;
    push(S_F); push(S_D); push(S_AE); push(S_AW);
    push(S_F); push(S_D); push(S_J);
    while (q.size() > 0) begin
      if (i == 4) begin
        op = 6'b000010;
        exp_count = exp_count + 1'b1;
        #1; total++;
        if (instr_count !== exp_count) begin
          bad++; $display("FAIL b2b_addi_count got=%0d want=%0d", instr_count, exp_count);
        end
      end
      #1; e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++; $display("FAIL b2b cyc%0d got=%b want=%b", i, obs, e.v);
      end
      @(posedge clk); @(negedge clk); i++;
    end
    exp_count = exp_count + 1'b1;
    zero = 1'b0;
    #1; total++;
    if (instr_count !== exp_count) begin
      bad++; $display("FAIL b2b_j_count got=%0d want=%0d", instr_count, exp_count);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    int i = 0;
    op = 6'b111111;
    push(S_F); push(S_D);
    for (int k = 0; k < 20; k++) push(S_H);
    while (q.size() > 0) begin
      #1; e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++; $display("FAIL halt_op cyc%0d got=%b want=%b", i, obs, e.v);
      end
      total++;
      if (illegal !== (i >= 2) || instr_count !== exp_count) begin
        bad++; $display("FAIL halt_op_regs cyc%0d got ill=%b cnt=%0d want ill=%b cnt=%0d",
                        i, illegal, instr_count, (i >= 2), exp_count);
      end
      @(posedge clk); @(negedge clk); i++;
    end
    reset = 1'b0;
    #1; total++;
    if (illegal !== 1'b0 || instr_count !== '0 || obs !== model(S_F, 1'b0, 6'h0, 1'b1)) begin
      bad++; $display("FAIL halt_reset got ill=%b cnt=%0d out=%b want ill=0 cnt=0 out=%b",
                      illegal, instr_count, obs, model(S_F, 1'b0, 6'h0, 1'b1));
    end
    exp_count = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    // Unknown R-type funct halts from EXECUTE; its alucontrol is not defined.
    i = 0;
    op = 6'b000000; funct = 6'b111111;
    push(S_F); push(S_D); push(S_EX); push(S_H); push(S_H); push(S_H);
    q[2].m = 15'h7ff8;
    while (q.size() > 0) begin
      #1; e = q.pop_front();
      total++;
      if ((obs & e.m) !== (e.v & e.m) || illegal !== (i >= 3)) begin
        bad++; $display("FAIL halt_fn cyc%0d got=%b ill=%b want=%b ill=%b",
                        i, obs & e.m, illegal, e.v & e.m, (i >= 3));
      end
      @(posedge clk); @(negedge clk); i++;
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1; funct = 6'h0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int i = 0;
    op = 6'b101011;
    push(S_F); push(S_D); push(S_MA); push(S_MWR);
    while (q.size() > 0) begin
      #1; e = q.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++; $display("FAIL rmid_pre cyc%0d got=%b want=%b", i, obs, e.v);
      end
      if (q.size() > 0) begin
        @(posedge clk); @(negedge clk);
      end
      i++;
    end
    // Still inside the MEMWR cycle, well before the next edge.
    #1; reset = 1'b0;
    #1; total++;
    if (memwrite !== 1'b0 || obs !== model(S_F, 1'b0, 6'h0, 1'b1) || instr_count !== '0) begin
      bad++; $display("FAIL rmid_abort got mw=%b out=%b cnt=%0d want mw=0 out=%b cnt=0",
                      memwrite, obs, instr_count, model(S_F, 1'b0, 6'h0, 1'b1));
    end
    @(negedge clk);
    reset = 1'b1; op = 6'b100011;
    push(S_F); push(S_D);
    i = 0;
    while (q.size() > 0) begin
      #1; e = q.pop_front();
      total++;
      if (obs !== e.v || instr_count !== '0) begin
        bad++; $display("FAIL rmid_restart cyc%0d got=%b cnt=%0d want=%b cnt=0", i, obs, instr_count, e.v);
      end
      @(posedge clk); @(negedge clk); i++;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Control unit for the multi-cycle MIPS datapath instantiated under the MIPS top level.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over shared memory/ALU resources.
- Includes the ALU function decoder, sticky illegal-opcode detection and a retired-instruction counter for bench visibility.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- op  input  6  instruction[31:26] from the instruction register.
- funct  input  6  instruction[5:0] from the instruction register.
- zero  input  1  ALU zero flag.
- pcen  output  1  PC load enable; equals pcwrite | (branch & zero).
- memwrite  output  1  data memory write strobe.
- irwrite  output  1  instruction register load.
- regwrite  output  1  register file write.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memtoreg  output  1  writeback select: 0 = ALUOut, 1 = MDR.
- regdst  output  1  destination select: 0 = rt, 1 = rd.
- alusrca  output  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  output  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  output  1  sticky flag; high once an unsupported opcode has been decoded.
- instr_count  output  CNT_W  number of instructions retired since reset.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- All listed outputs are Moore decodes of state, except pcen (uses zero) and alucontrol (uses funct).
- While reset is low:
  - state = FETCH, illegal = 0, instr_count = 0.
  - All write enables (pcen, memwrite, irwrite, regwrite) are forced to 0.
- First FETCH occurs on the first rising edge after reset deasserts.
- Reset asserted mid-instruction aborts it immediately; no partial write may occur after reset falls.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, pcwrite=1. Next state: DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=add (branch target into ALUOut). Next state by op:
  - 100011 lw, 101011 sw -> MEMADR.
  - 000000 R-type -> EXECUTE.
  - 000100 beq -> BRANCH.
  - 001000 addi -> ADDIEX.
  - 000010 j -> JUMP.
  - any other op -> HALT.
- MEMADR: alusrca=1, alusrcb=10, add. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next: MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR: iord=1, memwrite=1. Next: FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct -> HALT.
  - Otherwise next: ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next: FETCH.
- HALT:
  - All write enables 0; illegal set on entry and held.
  - Remains in HALT until reset.
  - instr_count frozen.
- alucontrol is add (010) in every state except EXECUTE and BRANCH.
- Unlisted outputs are 0 in each state.
- instr_count increments by 1 on every transition into FETCH from a non-reset state (instruction retire). Wraps modulo 2^CNT_W without flagging.
- Latency in cycles (FETCH through return to FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- beq not taken (zero=0 in BRANCH): pcen=0 that cycle; PC already holds PC+4 from FETCH.
- zero is ignored in every state except BRANCH.

Test Plan:
- Reset held 3 cycles, then op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; instr_count=1 on return to FETCH.
- op=000000, funct=100010 -> alucontrol=110 in EXECUTE; regwrite=1 with regdst=1 in ALUWB; 4 cycles total.
- op=000100 with zero=1 -> pcen=1, pcsrc=01 in BRANCH. Repeat with zero=0 -> pcen=0; both take 3 cycles.
- op=101011 (sw) -> memwrite=1 and iord=1 in cycle 4 only; regwrite never asserted.
- op=111111 -> HALT after DECODE; illegal=1, all enables 0 for 20 cycles; instr_count unchanged. Reset low -> illegal=0, instr_count=0.
- reset dropped during MEMWR -> memwrite deasserts asynchronously in the same cycle. After release, FETCH with pcwrite=1 occurs on the first edge.
